// File: rtl/ex_div_pkg.sv
// Shared constants for the execute-stage divider: funct3 codes, FSM states and
// write-back encodings.
package ex_div_pkg;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } div_state_e;

  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  ZeroReg      = 5'd0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;

endpackage

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish immediately.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic [4:0]        reg_waddr_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              ready_o,
  output logic [DATA_W-1:0] result_o,
  output logic              reg_we_o,
  output logic [4:0]        reg_waddr_o
);

  localparam logic [DATA_W-1:0] MinInt = {1'b1, {(DATA_W-1){1'b0}}};

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
    return ~x + DATA_W'(1);
  endfunction

  div_state_e        state_q;
  logic              busy_q, ready_q, is_rem_q, neg_quot_q, neg_rem_q;
  logic [DATA_W-1:0] result_q, divisor_q, rem_q;
  // Holds the dividend magnitude; quotient bits shift in at the bottom.
  logic [DATA_W-1:0] dividend_q;
  logic [4:0]        waddr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              op_signed, op_rem, sign_a, sign_b, div_zero, overflow, q_bit;
  logic [DATA_W-1:0] abs_a, abs_b, special_res, rem_next, quot_next, quot_fin, rem_fin;
  logic [DATA_W:0]   rem_shift, rem_diff;

  always_comb begin
    op_signed   = (op_i == INST_DIV) || (op_i == INST_REM);
    op_rem      = (op_i == INST_REM) || (op_i == INST_REMU);
    sign_a      = op_signed & dividend_i[DATA_W-1];
    sign_b      = op_signed & divisor_i[DATA_W-1];
    abs_a       = sign_a ? negate(dividend_i) : dividend_i;
    abs_b       = sign_b ? negate(divisor_i) : divisor_i;
    div_zero    = (divisor_i == '0);
    overflow    = op_signed && (dividend_i == MinInt) && (divisor_i == '1);
    special_res = div_zero ? (op_rem ? dividend_i : '1) : (op_rem ? '0 : MinInt);

    rem_shift = {rem_q, dividend_q[DATA_W-1]};
    rem_diff  = rem_shift - {1'b0, divisor_q};
    q_bit     = ~rem_diff[DATA_W];
    rem_next  = q_bit ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
    quot_next = {dividend_q[DATA_W-2:0], q_bit};
    quot_fin  = neg_quot_q ? negate(quot_next) : quot_next;
    rem_fin   = neg_rem_q ? negate(rem_next) : rem_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      ready_q    <= WriteDisable;
      result_q   <= DATA_W'(ZeroWord);
      waddr_q    <= ZeroReg;
      is_rem_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
    end else begin
      ready_q  <= WriteDisable;
      result_q <= DATA_W'(ZeroWord);
      case (state_q)
        StIdle: begin
          if (start_i && op_i[2] && !flush_i) begin
            busy_q     <= 1'b1;
            waddr_q    <= reg_waddr_i;
            is_rem_q   <= op_rem;
            neg_quot_q <= sign_a ^ sign_b;
            neg_rem_q  <= sign_a;
            dividend_q <= abs_a;
            divisor_q  <= abs_b;
            rem_q      <= '0;
            cnt_q      <= '0;
            if (div_zero || overflow) begin
              state_q  <= StDone;
              ready_q  <= WriteEnable;
              result_q <= special_res;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          if (flush_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            dividend_q <= quot_next;
            rem_q      <= rem_next;
            cnt_q      <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              state_q  <= StDone;
              ready_q  <= WriteEnable;
              result_q <= is_rem_q ? rem_fin : quot_fin;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A flush landing in the result cycle still suppresses the write-back.
  assign ready_o     = ready_q & ~flush_i;
  assign reg_we_o    = ready_o;
  assign busy_o      = busy_q;
  assign result_o    = result_q;
  assign reg_waddr_o = waddr_q;

endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div; cycle 0 is the cycle in which start_i is presented.
module tb_ex_div;
  import ex_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i, divisor_i;
  logic [4:0]  reg_waddr_i;
  logic        busy_o, ready_o, reg_we_o;
  logic [31:0] result_o;
  logic [4:0]  reg_waddr_o;

  int checks = 0;
  int errors = 0;

  ex_div #(.DATA_W(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .reg_waddr_i(reg_waddr_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .result_o   (result_o),
    .reg_we_o   (reg_we_o),
    .reg_waddr_o(reg_waddr_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a start in the current cycle (cycle 0); returns in cycle 1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa);
    op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = wa; start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Steps until ready_o or the bound; cyc is the cycle number reached.
  task automatic wait_ready(input int max_cyc, output int cyc, output logic busy_ok);
    cyc = 1; busy_ok = 1'b1;
    while (!ready_o && cyc < max_cyc) begin
      if (!busy_o) busy_ok = 1'b0;
      step();
      cyc++;
    end
    if (!busy_o) busy_ok = 1'b0;
  endtask

  task automatic watch_ready(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (ready_o || reg_we_o) seen = 1'b1;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = 3'b000;
    dividend_i = '0; divisor_i = '0; reg_waddr_i = '0;
    step(); step();
    checks++;
    if ({busy_o, ready_o, reg_we_o, result_o, reg_waddr_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b ready=%b we=%b res=%h wa=%0d want all 0",
               busy_o, ready_o, reg_we_o, result_o, reg_waddr_o);
    end
    rst = 1'b1;
    step();
  endtask

  // Full-latency check of one normal division with a hand-computed result.
  task automatic test_normal(input string name, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] wa,
                             input logic [31:0] exp);
    int cyc; logic busy_ok;
    issue(op, a, b, wa);
    wait_ready(40, cyc, busy_ok);
    checks++;
    if (cyc != 33 || !ready_o) begin
      errors++; $display("FAIL %s_latency: got cycle %0d ready=%b want cycle 33", name, cyc, ready_o);
    end
    checks++;
    if (!busy_ok) begin
      errors++; $display("FAIL %s_busy: busy_o dropped before result, want high cycles 1..33", name);
    end
    checks++;
    if (result_o !== exp || reg_we_o !== 1'b1 || reg_waddr_o !== wa) begin
      errors++;
      $display("FAIL %s_result: got res=%h we=%b wa=%0d want res=%h we=1 wa=%0d",
               name, result_o, reg_we_o, reg_waddr_o, exp, wa);
    end
    step();
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 32'h0) begin
      errors++;
      $display("FAIL %s_after: got busy=%b ready=%b res=%h want 0 0 0", name, busy_o, ready_o,
               result_o);
    end
  endtask

  task automatic test_special(input string name, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp);
    issue(op, a, b, 5'd12);
    checks++;
    if (ready_o !== 1'b1 || busy_o !== 1'b1 || result_o !== exp || reg_waddr_o !== 5'd12) begin
      errors++;
      $display("FAIL %s: cycle1 got ready=%b busy=%b res=%h wa=%0d want 1 1 %h 12",
               name, ready_o, busy_o, result_o, reg_waddr_o, exp);
    end
    step();
    checks++;
    if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL %s_after: got ready=%b busy=%b want 0 0", name, ready_o, busy_o);
    end
  endtask

  task automatic test_flush();
    int cyc; logic busy_ok, seen;
    issue(INST_DIVU, 32'd1000, 32'd7, 5'd7);
    for (int i = 1; i < 10; i++) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++; $display("FAIL flush_cycle11: got busy=%b ready=%b want 0 0", busy_o, ready_o);
    end
    // Restart in cycle 11: result due in cycle 44.
    issue(INST_DIVU, 32'd9, 32'd3, 5'd9);
    wait_ready(40, cyc, busy_ok);
    checks++;
    if (cyc + 11 != 44 || !ready_o || result_o !== 32'd3 || reg_waddr_o !== 5'd9) begin
      errors++;
      $display("FAIL flush_restart: got cycle %0d ready=%b res=%h wa=%0d want cycle 44 res=3 wa=9",
               cyc + 11, ready_o, result_o, reg_waddr_o);
    end
    step();
    // Start together with flush in idle is dropped.
    flush_i = 1'b1;
    issue(INST_DIVU, 32'd4, 32'd2, 5'd1);
    flush_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL flush_start: got busy=%b want 0", busy_o);
    end
    watch_ready(40, seen);
    checks++;
    if (seen) begin
      errors++; $display("FAIL flush_start_ready: got a ready pulse want none");
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    issue(INST_DIVU, 32'd1000, 32'd3, 5'd17);
    for (int i = 1; i < 20; i++) step();
    rst = 1'b0;
    step();
    checks++;
    if ({busy_o, ready_o, reg_we_o, result_o, reg_waddr_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b ready=%b we=%b res=%h wa=%0d want all 0",
               busy_o, ready_o, reg_we_o, result_o, reg_waddr_o);
    end
    rst = 1'b1;
    watch_ready(40, seen);
    checks++;
    if (seen || busy_o) begin
      errors++; $display("FAIL reset_mid_quiet: got ready seen=%b busy=%b want 0 0", seen, busy_o);
    end
  endtask

  task automatic test_ignored();
    int cyc; logic busy_ok, seen;
    issue(INST_DIVU, 32'd50, 32'd5, 5'd3);
    step(); step(); step();
    issue(INST_DIV, 32'd7, 32'd1, 5'd4);
    wait_ready(40, cyc, busy_ok);
    checks++;
    if (cyc + 4 != 33 || result_o !== 32'd10 || reg_waddr_o !== 5'd3) begin
      errors++;
      $display("FAIL busy_start: got cycle %0d res=%h wa=%0d want cycle 33 res=a wa=3",
               cyc + 4, result_o, reg_waddr_o);
    end
    // A start held in the done cycle must not be taken either.
    issue(INST_DIVU, 32'd8, 32'd2, 5'd6);
    watch_ready(40, seen);
    checks++;
    if (seen) begin
      errors++; $display("FAIL done_or_busy_start: got extra ready pulse want none");
    end
    issue(3'b000, 32'd8, 32'd2, 5'd6);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL non_div_op_busy: got busy=%b want 0", busy_o);
    end
    watch_ready(40, seen);
    checks++;
    if (seen) begin
      errors++; $display("FAIL non_div_op_ready: got ready pulse want none");
    end
  endtask

  task automatic test_back_to_back();
    int cyc; logic busy_ok;
    issue(INST_REMU, 32'd100, 32'd7, 5'd21);
    wait_ready(40, cyc, busy_ok);
    step();
    // Cycle 34: idle again, second division accepted here.
    issue(INST_DIVU, 32'hFFFF_FFFF, 32'h10, 5'd22);
    wait_ready(40, cyc, busy_ok);
    checks++;
    if (cyc != 33 || result_o !== 32'h0FFF_FFFF || reg_waddr_o !== 5'd22) begin
      errors++;
      $display("FAIL back_to_back: got cycle %0d res=%h wa=%0d want cycle 33 res=0fffffff wa=22",
               cyc, result_o, reg_waddr_o);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_normal("divu_100_7", INST_DIVU, 32'd100, 32'd7, 5'd5, 32'd14);
    test_normal("remu_100_7", INST_REMU, 32'd100, 32'd7, 5'd6, 32'd2);
    test_normal("rem_m7_2", INST_REM, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF);
    test_normal("div_m7_2", INST_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD);
    test_normal("div_20_m3", INST_DIV, 32'd20, 32'hFFFF_FFFD, 5'd10, 32'hFFFF_FFFA);
    test_normal("rem_20_m3", INST_REM, 32'd20, 32'hFFFF_FFFD, 5'd11, 32'd2);
    test_normal("remu_big", INST_REMU, 32'hFFFF_FFFF, 32'h10, 5'd31, 32'hF);
    test_special("div_by_zero", INST_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
    test_special("divu_by_zero", INST_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
    test_special("remu_by_zero", INST_REMU, 32'd5, 32'd0, 32'd5);
    test_special("rem_by_zero", INST_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    test_special("div_overflow", INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    test_special("rem_overflow", INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    test_normal("divu_no_ovf", INST_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h0);
    test_flush();
    test_reset_mid();
    test_ignored();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle radix-2 restoring divider in the execute stage.
- Consumes the decoded operands and destination register registered by the ID/EX pipeline register.
- Executes RV32M DIV/DIVU/REM/REMU.
- Returns the result with a write-back request; busy_o feeds the pipeline stall logic so the ID/EX register holds while a division is in flight.

Parameters:
- DATA_W, 32, operand/result width (only 32 is verified).
- CNT_W, 6, iteration counter width (must hold DATA_W).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-low reset
- start_i  input  1  request a division this cycle
- op_i  input  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
- dividend_i  input  DATA_W  rs1 value (op1)
- divisor_i  input  DATA_W  rs2 value (op2)
- reg_waddr_i  input  5  destination register
- flush_i  input  1  abort (jump/interrupt hold from ctrl)
- busy_o  output  1  division in flight, stall ID/EX
- ready_o  output  1  one-cycle result-valid pulse
- result_o  output  DATA_W  quotient or remainder
- reg_we_o  output  1  GPR write enable (equals ready_o)
- reg_waddr_o  output  5  destination register for the result

Behaviour:
- Reset and clock: reset rst, synchronous, active-low; clock clk.
- Reset values: state IDLE; busy_o 0; ready_o 0; reg_we_o 0; result_o 0; reg_waddr_o 0; internal counter, remainder and quotient cleared. Reset has priority over every other input and aborts any operation mid-flight.
- States: IDLE, CALC, DONE.
- IDLE: start_i=1 with op_i[2]=1 is accepted. start_i with op_i[2]=0 is ignored.
  - On accept, latch op, reg_waddr_i and the operand magnitudes. For signed ops (op_i[0]=0) use |x| and record the quotient sign (sign_a XOR sign_b) and the remainder sign (sign_a).
  - divisor_i=0 or signed overflow (0x80000000 / 0xFFFFFFFF): go directly to DONE with the special result.
  - Otherwise go to CALC with counter=0.
- CALC: one shift-subtract iteration per cycle.
  - rem = {rem[DATA_W-2:0], dividend msb}; if rem >= divisor then rem -= divisor and the quotient bit is 1.
  - After DATA_W iterations (counter reaches DATA_W-1) go to DONE.
  - Signs are applied at the DONE transition via two's-complement negation.
- DONE: ready_o=1 and reg_we_o=1 for exactly one cycle; result_o and reg_waddr_o are valid. Then IDLE.
- Outputs outside DONE: ready_o=0, reg_we_o=0, result_o=0.
- busy_o = (state != IDLE), registered. ctrl stalls on start_i | busy_o.
- Latency (start sampled in cycle 0):
  - Normal: busy_o high cycles 1..33; ready_o in cycle 33.
  - Special cases: ready_o in cycle 1.
- start_i while busy is ignored; no queueing.
- A new start is accepted in the cycle after DONE, i.e. IDLE. Back-to-back throughput is one division per 34 cycles.
- Special results:
  - x/0: quotient 0xFFFFFFFF (DIV and DIVU); remainder x (REM and REMU).
  - Overflow: DIV gives 0x80000000; REM gives 0.
- flush_i in CALC or DONE: next state IDLE, no ready_o and no write.
- flush_i with start_i in IDLE: the start is ignored.
- flush_i has lower priority than reset and higher priority than start.
- Arithmetic: remainder register is DATA_W+1 bits for the compare/subtract. All negation is modulo 2^DATA_W.

Decomposition:
- Shared defines: funct3 codes INST_DIV/DIVU/REM/REMU, state encodings, ZeroWord, ZeroReg, WriteEnable/WriteDisable. These constants go in defines.v.
- No sub-module; the single FSM plus datapath is in one file.

Test Plan:
- DIVU 100/7, start in cycle 0 -> busy_o cycles 1-33; ready_o in cycle 33 with result 14; reg_waddr_o equals the input value (5).
- REM 0xFFFFFFF9 (-7) / 2 -> result 0xFFFFFFFF (-1). DIV of the same operands -> 0xFFFFFFFD (-3).
- DIV 5/0 -> ready_o in cycle 1, result 0xFFFFFFFF. REMU 5/0 -> 5.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1. REM of the same operands -> 0.
- Start DIVU, then flush_i in cycle 10 -> busy_o 0 in cycle 11 and no ready_o ever. A new start in cycle 11 (DIVU 9/3) -> 3 in cycle 44.
- rst=0 in cycle 20 mid-CALC -> all outputs 0 next cycle. start_i while busy, and start with op_i=000, are ignored (no second ready_o).
